io_uart_bridge: RTL
===================

Name: io_uart_bridge

Overview:
- Host-side counterpart of the processor's memory-mapped I/O ports (in0..in2 / out0..out2).
- A PC talks to it over a UART link to drive the processor's input words and read back its output words.
- Sits at the FPGA top level beside the processor.
- Its in0..in2 outputs connect to the processor's in0..in2 inputs, and the processor's out0..out2 outputs connect to its out0..out2 inputs.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be >= 4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- uart_rx  input  1  serial in from host; asynchronous, idle high
- uart_tx  output  1  serial out to host; idle high
- out0  input  32  processor output word 0
- out1  input  32  processor output word 1
- out2  input  32  processor output word 2
- in0  output  32  word driven to processor input 0
- in1  output  32  word driven to processor input 1
- in2  output  32  word driven to processor input 2
- busy  output  1  high while a command is in progress (WDATA or TX state)
- err  output  1  one-cycle pulse on a framing error or bad/dropped command

Behaviour:
- Reset is synchronous and active-low: rst==0 at a clk edge resets all state. Reset takes effect mid-frame as well: the partial byte or command is discarded and any in-progress TX byte is truncated.
- Reset values: in0/in1/in2=0, uart_tx=1, busy=0, err=0, FSM=CMD.
- Serial format: 8N1, LSB first.
- RX input conditioning: uart_rx passes through a 2-flop synchronizer before any use.
- RX start detection: a high-to-low transition on the synchronized line starts a frame.
- RX start check: wait CLKS_PER_BIT/2 (integer division). If the line is back high, the start was a glitch; return to idle with no err.
- RX bit sampling: sample 8 data bits, then the stop bit, at CLKS_PER_BIT intervals after the start-bit midpoint.
- Stop bit low: byte discarded, err pulses, RX waits for the line to go high before rearming.
- Good byte: rx_valid pulses for 1 cycle on the stop-bit sample cycle.
- Command byte 0x00|k (k=0..2): write in[k]. FSM moves to WDATA and collects 4 bytes little-endian (first byte = bits 7:0).
  - in[k] updates the cycle after the 4th byte's rx_valid. The other in words are unchanged.
  - The partial word is never visible on in[k].
- Command byte 0x80|k (k=0..2): read out[k]. out[k] is snapshotted on the rx_valid cycle of the command byte and FSM moves to TX.
  - The start bit of byte 0 begins the cycle after the snapshot.
  - 4 bytes are sent little-endian, back-to-back, 10 bits each, each bit exactly CLKS_PER_BIT cycles.
  - Total TX time is 40*CLKS_PER_BIT cycles, after which FSM returns to CMD.
- Any other command byte (k=3, or bits 6:2 nonzero): ignored, err pulses, FSM stays in CMD.
- FSM states and transitions:
  - CMD -> WDATA (write command)
  - CMD -> TX (read command)
  - WDATA -> CMD (after the 4th byte)
  - TX -> CMD (after the last stop bit)
- Bytes received while in TX are dropped with an err pulse. The receiver keeps running, so framing stays aligned.
- No timeout in WDATA: a host that sends fewer than 4 bytes leaves the bridge waiting. Recovery is by reset.
- busy=1 exactly while FSM is in WDATA or TX.
- Counters: the bit-period counter is $clog2(CLKS_PER_BIT) bits wide; bit index 0..9; byte index 0..3. No counter may wrap past its terminal value.

Decomposition:
- Shared package io_uart_pkg holds:
  - FSM state enum (CMD, WDATA, TX)
  - command encodings CMD_WR=2'b00 and CMD_RD=2'b10 in bits 7:6
  - port-index width
  - UART bit-count constants
- One sub-module, uart_rx_byte: synchronizer, start check, sampling, framing error, rx_valid/rx_data.
- The TX shifter and the command FSM stay in io_uart_bridge.

Test Plan (CLKS_PER_BIT=4):
- Reset mid-stream: drive rst=0 during a partial write frame -> in0..in2=0, uart_tx=1, busy=0; the next command decodes correctly.
- Write: send 0x01,0x78,0x56,0x34,0x12 -> in1=0x12345678 the cycle after the last rx_valid; in0 and in2 unchanged; busy high from command to commit.
- Read: out2=0xDEADBEEF, send 0x82 -> uart_tx emits 0xEF,0xBE,0xAD,0xDE in 160 cycles. Changing out2 during TX does not alter the bytes sent.
- Bad command: send 0x03, then 0x44 -> two err pulses, no in change, busy stays 0.
- Framing error: send a byte with stop bit low -> err pulse, byte ignored; a following valid 0x80 read returns out0.
- Glitch: a 1-cycle low on uart_rx -> no byte, no err.

Source files
------------

// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared types and constants for the UART I/O bridge
package io_uart_pkg;

   typedef enum logic [1:0] {
      CMD   = 2'd0,
      WDATA = 2'd1,
      TX    = 2'd2
   } state_t;

   localparam logic [1:0] CMD_WR = 2'b00;
   localparam logic [1:0] CMD_RD = 2'b10;

   localparam int PORT_W     = 2;
   localparam int NUM_PORTS  = 3;
   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver with synchronizer, start check and framing error
module uart_rx_byte
   import io_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_END = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP,
      R_WAIT
   } rx_state_t;

   rx_state_t            state, state_n;
   logic                 rx_meta, rx_s, rx_prev;
   logic [CW-1:0]        cnt, cnt_n;
   logic [BW-1:0]        bit_idx, bit_n;
   logic [DATA_BITS-1:0] shift, shift_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
         state   <= R_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
      end
   end

   // Samples are taken at the start-bit midpoint plus whole bit periods.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_n     = bit_idx;
      shift_n   = shift;
      rx_valid  = 1'b0;
      frame_err = 1'b0;
      case (state)
         R_IDLE: begin
            if (rx_prev && !rx_s) begin
               state_n = R_START;
               cnt_n   = '0;
            end
         end
         R_START: begin
            if (cnt == HALF_M1) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = rx_s ? R_IDLE : R_DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         R_DATA: begin
            if (cnt == LAST) begin
               cnt_n   = '0;
               shift_n = {rx_s, shift[DATA_BITS-1:1]};
               if (bit_idx == BIT_END) state_n = R_STOP;
               else                    bit_n   = bit_idx + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         R_STOP: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  rx_valid = 1'b1;
                  state_n  = R_IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_n   = R_WAIT;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         R_WAIT: begin
            if (rx_s) state_n = R_IDLE;
         end
         default: state_n = R_IDLE;
      endcase
   end

   assign rx_data = shift;

endmodule

// File: rtl/io_uart_bridge.sv
// rtl/io_uart_bridge.sv - UART host bridge driving in0..in2 and reading back out0..out2
module io_uart_bridge
   import io_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic        uart_tx,
   input  logic [31:0] out0,
   input  logic [31:0] out1,
   input  logic [31:0] out2,
   output logic [31:0] in0,
   output logic [31:0] in1,
   output logic [31:0] in2,
   output logic        busy,
   output logic        err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);
   localparam logic [1:0]    BYTE_END = 2'(WORD_BYTES - 1);

   logic                 rx_valid, rx_ferr;
   logic [DATA_BITS-1:0] rx_data;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (uart_rx),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .frame_err (rx_ferr)
   );

   state_t              state, state_n;
   logic [PORT_W-1:0]   port;
   logic [2:0][31:0]    in_q;
   logic [23:0]         wbuf;
   logic [1:0]          byte_idx;
   logic [31:0]         tx_word;
   logic [9:0]          tx_frame;
   logic [CW-1:0]       tx_cnt;
   logic [3:0]          tx_bit;
   logic                cmd_ok, cmd_rd, tx_done, err_n;
   logic [31:0]         out_sel;

   always_comb begin
      state_n = state;
      err_n   = rx_ferr;
      cmd_ok  = ((rx_data[7:6] == CMD_WR) || (rx_data[7:6] == CMD_RD))
                && (rx_data[5:PORT_W] == '0)
                && (rx_data[PORT_W-1:0] < PORT_W'(NUM_PORTS));
      cmd_rd  = (rx_data[7:6] == CMD_RD);
      tx_done = (tx_cnt == LAST) && (tx_bit == BIT_LAST) && (byte_idx == BYTE_END);
      case (rx_data[PORT_W-1:0])
         2'd0:    out_sel = out0;
         2'd1:    out_sel = out1;
         default: out_sel = out2;
      endcase
      case (state)
         CMD: begin
            if (rx_valid) begin
               if (cmd_ok) state_n = cmd_rd ? TX : WDATA;
               else        err_n   = 1'b1;
            end
         end
         WDATA: begin
            if (rx_valid && byte_idx == BYTE_END) state_n = CMD;
         end
         TX: begin
            if (rx_valid) err_n = 1'b1;
            if (tx_done)  state_n = CMD;
         end
         default: state_n = CMD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= CMD;
         err      <= 1'b0;
         port     <= '0;
         in_q     <= '0;
         wbuf     <= '0;
         byte_idx <= '0;
         tx_word  <= '0;
         tx_frame <= '1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
      end else begin
         state <= state_n;
         err   <= err_n;
         case (state)
            CMD: begin
               if (rx_valid && cmd_ok) begin
                  port     <= rx_data[PORT_W-1:0];
                  byte_idx <= '0;
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  if (cmd_rd) begin
                     tx_frame <= {1'b1, out_sel[7:0], 1'b0};
                     tx_word  <= {8'h00, out_sel[31:8]};
                  end
               end
            end
            WDATA: begin
               // Bytes collect in wbuf so a partial word never reaches in_q.
               if (rx_valid) begin
                  if (byte_idx == BYTE_END) begin
                     case (port)
                        2'd0:    in_q[0] <= {rx_data, wbuf};
                        2'd1:    in_q[1] <= {rx_data, wbuf};
                        default: in_q[2] <= {rx_data, wbuf};
                     endcase
                  end else begin
                     wbuf     <= {rx_data, wbuf[23:8]};
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            TX: begin
               if (tx_cnt == LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == BIT_LAST) begin
                     tx_bit <= '0;
                     if (byte_idx != BYTE_END) begin
                        byte_idx <= byte_idx + 1'b1;
                        tx_frame <= {1'b1, tx_word[7:0], 1'b0};
                        tx_word  <= {8'h00, tx_word[31:8]};
                     end else begin
                        tx_frame <= '1;
                     end
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_frame <= {1'b1, tx_frame[9:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign uart_tx = tx_frame[0];
   assign busy    = (state != CMD);
   assign in0     = in_q[0];
   assign in1     = in_q[1];
   assign in2     = in_q[2];

endmodule
